// File: rtl/dpram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dpram_pkg                                                 |
// | Purpose  : Shared constants for the dual-port RAM and its port logic |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dpram_pkg;

    localparam int RDW_NO_CHANGE   = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_WRITE_FIRST = 2;

    typedef logic [1:0] clr_state_t;

    localparam clr_state_t IDLE  = 2'd0;
    localparam clr_state_t CLEAR = 2'd1;
    localparam clr_state_t READY = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dpram_port_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dpram_port_out                                            |
// | Purpose  : Per-port read data / valid path with read-during-write    |
// |            selection and an optional output pipeline stage           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dpram_port_out
    import dpram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_acc,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_q,
    output logic              o_q_valid
);

    logic [DATA_W-1:0] r_q_q;
    logic [DATA_W-1:0] w_q_d;
    logic              r_valid_q;
    logic              w_valid_d;

    // i_rdata is the pre-write memory content, so it doubles as the READ_FIRST value
    always_comb begin
        w_q_d     = r_q_q;
        w_valid_d = 1'b0;
        if (i_acc) begin
            if (!i_we) begin
                w_q_d     = i_rdata;
                w_valid_d = 1'b1;
            end else if (RDW_MODE == RDW_READ_FIRST) begin
                w_q_d     = i_rdata;
                w_valid_d = 1'b1;
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                w_q_d     = i_wdata;
                w_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_q     <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_q_q     <= w_q_d;
            r_valid_q <= w_valid_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_q2_q;
            logic [DATA_W-1:0] w_q2_d;
            logic              r_valid2_q;
            logic              w_valid2_d;

            always_comb begin
                w_q2_d     = r_q_q;
                w_valid2_d = r_valid_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q2_q     <= '0;
                    r_valid2_q <= 1'b0;
                end else begin
                    r_q2_q     <= w_q2_d;
                    r_valid2_q <= w_valid2_d;
                end
            end

            assign o_q       = r_q2_q;
            assign o_q_valid = r_valid2_q;
        end else begin : g_no_out_reg
            assign o_q       = r_q_q;
            assign o_q_valid = r_valid_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dual_port_ram_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dual_port_ram_cfg                                         |
// | Purpose  : True dual-port synchronous RAM with collision handling,   |
// |            selectable read-during-write and post-reset clear sweep   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dual_port_ram_cfg
    import dpram_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 6,
    parameter int RDW_MODE     = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,
    output logic              q_valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b,
    output logic              q_valid_b,
    output logic              busy,
    output logic              col_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    clr_state_t        r_state_q;
    clr_state_t        w_state_d;
    logic [ADDR_W-1:0] r_cnt_q;
    logic [ADDR_W-1:0] w_cnt_d;
    logic              w_busy;
    logic              w_clr_we;

    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_wr_a;
    logic              w_wr_b;
    logic              w_col;
    logic              r_col_err_q;
    logic              w_col_err_d;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;

    // Clear FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // Clear FSM: next state
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            CLEAR: begin
                w_cnt_d = r_cnt_q + ADDR_W'(1);
                if (r_cnt_q == {ADDR_W{1'b1}}) begin
                    w_state_d = READY;
                end
            end
            default: begin
                w_state_d = r_state_q;
            end
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        w_busy   = (r_state_q == CLEAR) || (rst && (CLEAR_ON_RST != 0));
        w_clr_we = (r_state_q == CLEAR) && !rst;
    end

    assign busy = w_busy;

    always_comb begin
        w_acc_a = en_a && !w_busy && !rst;
        w_acc_b = en_b && !w_busy && !rst;
        w_col   = w_acc_a && we_a && w_acc_b && we_b && (addr_a == addr_b);
        w_wr_a  = w_acc_a && we_a;
        // Port A wins a same-address write; port B's data is dropped
        w_wr_b  = w_acc_b && we_b && !w_col;
        w_col_err_d = w_col;
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt_q] <= '0;
        end else begin
            if (w_wr_a) begin
                r_mem[addr_a] <= data_a;
            end
            if (w_wr_b) begin
                r_mem[addr_b] <= data_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_err_q <= 1'b0;
        end else begin
            r_col_err_q <= w_col_err_d;
        end
    end

    assign col_err   = r_col_err_q;
    assign w_rdata_a = r_mem[addr_a];
    assign w_rdata_b = r_mem[addr_b];

    dpram_port_out #(
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE),
        .OUT_REG  (OUT_REG)
    ) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .i_acc     (w_acc_a),
        .i_we      (we_a),
        .i_wdata   (data_a),
        .i_rdata   (w_rdata_a),
        .o_q       (q_a),
        .o_q_valid (q_valid_a)
    );

    dpram_port_out #(
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE),
        .OUT_REG  (OUT_REG)
    ) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .i_acc     (w_acc_b),
        .i_we      (we_b),
        .i_wdata   (data_b),
        .i_rdata   (w_rdata_b),
        .o_q       (q_b),
        .o_q_valid (q_valid_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dual_port_ram_cfg                                      |
// | Purpose  : Four RAM configurations driven by shared directed stimulus|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_dual_port_ram_cfg;

    // u0: NO_CHANGE + clear, u1: READ_FIRST, u2: WRITE_FIRST, u3: NO_CHANGE + OUT_REG
    localparam int MODE [4] = '{0, 1, 2, 0};
    localparam int LAT  [4] = '{1, 1, 1, 2};

    typedef struct {
        logic [7:0] d;
        int         cyc;
        bit         chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [5:0] addr_a = '0, addr_b = '0;
    logic [7:0] data_a = '0, data_b = '0;
    logic [7:0] q_a [4];
    logic [7:0] q_b [4];
    logic       v_a [4];
    logic       v_b [4];
    logic       busy [4];
    logic       col [4];

    exp_t sb [8][$];
    int   col_q [4][$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_port_ram_cfg #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[0]), .q_valid_a(v_a[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[0]), .q_valid_b(v_b[0]),
        .busy(busy[0]), .col_err(col[0]));
    dual_port_ram_cfg #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RST(0)) u1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[1]), .q_valid_a(v_a[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[1]), .q_valid_b(v_b[1]),
        .busy(busy[1]), .col_err(col[1]));
    dual_port_ram_cfg #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RST(0)) u2 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[2]), .q_valid_a(v_a[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[2]), .q_valid_b(v_b[2]),
        .busy(busy[2]), .col_err(col[2]));
    dual_port_ram_cfg #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(0)) u3 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[3]), .q_valid_a(v_a[3]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[3]), .q_valid_b(v_b[3]),
        .busy(busy[3]), .col_err(col[3]));

    // Monitor: pops the scoreboard whenever a valid or collision pulse appears
    always @(negedge clk) begin : mon
        logic       mv;
        logic [7:0] mq;
        exp_t       e;
        int         ec;
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 2; p++) begin
                mv = (p == 0) ? v_a[i] : v_b[i];
                mq = (p == 0) ? q_a[i] : q_b[i];
                if (mv === 1'b1) begin
                    n_tests++;
                    if (sb[p*4+i].size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_u%0d_p%0d: unexpected valid q=%h at cyc %0d", i, p, mq, cyc);
                    end else begin
                        e = sb[p*4+i].pop_front();
                        if (e.cyc != cyc || (e.chk && mq !== e.d)) begin
                            n_fail++;
                            $display("FAIL rd_u%0d_p%0d: got q=%h at cyc %0d, expected q=%h at cyc %0d",
                                     i, p, mq, cyc, e.d, e.cyc);
                        end
                    end
                end
            end
            if (col[i] === 1'b1) begin
                n_tests++;
                if (col_q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL col_u%0d: unexpected col_err at cyc %0d", i, cyc);
                end else begin
                    ec = col_q[i].pop_front();
                    if (ec != cyc) begin
                        n_fail++;
                        $display("FAIL col_u%0d: col_err at cyc %0d, expected cyc %0d", i, cyc, ec);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(int p, int i, logic [7:0] d, bit k);
        exp_t e;
        e.d   = d;
        e.cyc = cyc + LAT[i];
        e.chk = k;
        sb[p*4+i].push_back(e);
    endtask

    // Same-port write side effect on q for every instance selected in m
    task automatic wr(int p, logic [3:0] m, logic [7:0] old, bit oldk, logic [7:0] nw);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (MODE[i] == 1) push(p, i, old, oldk);
                else if (MODE[i] == 2) push(p, i, nw, 1'b1);
            end
        end
    endtask

    task automatic count_busy(string nm);
        int n;
        n = 0;
        while (busy[0] === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(nm, n, 64);
    endtask

    initial begin
        int n;
        logic [5:0] ra [3];
        logic [7:0] rd [3];

        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            chk("rst_q_a", q_a[i], 0);
            chk("rst_q_b", q_b[i], 0);
            chk("rst_valid", {v_a[i], v_b[i], col[i]}, 0);
        end
        chk("rst_busy_clear", busy[0], 1);
        chk("rst_busy_noclear", busy[1], 0);

        // Clear sweep with a write attempted during busy
        rst = 1'b0;
        n = 0;
        while (busy[0] === 1'b1 && n < 200) begin
            if (n == 0) begin
                en_a = 1'b1; we_a = 1'b1; addr_a = 6'd5; data_a = 8'h55;
                wr(0, 4'b1110, 8'h00, 1'b0, 8'h55);
            end
            tick();
            idle();
            n++;
        end
        chk("clear_busy_len", n, 64);
        chk("busy_noclear", busy[3], 0);

        // Reset in the middle of the sweep
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        repeat (20) begin
            if (busy[0] === 1'b1) n++;
            tick();
        end
        chk("mid_busy_20", n, 20);
        rst = 1'b1; tick();
        chk("mid_rst_busy", busy[0], 1);
        rst = 1'b0;
        count_busy("mid_busy_len");

        // Post-clear reads: cleared instance returns zero
        en_a = 1'b1; addr_a = 6'd5; en_b = 1'b1; addr_b = 6'd63;
        push(0, 0, 8'h00, 1'b1); push(1, 0, 8'h00, 1'b1);
        for (int i = 1; i < 4; i++) begin
            push(0, i, 8'h55, 1'b1); push(1, i, 8'h00, 1'b0);
        end
        tick(); idle();

        // Basic access
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd1; data_a = 8'h10;
        en_b = 1'b1; we_b = 1'b1; addr_b = 6'd2; data_b = 8'h20;
        wr(0, 4'hF, 8'h00, 1'b0, 8'h10); wr(1, 4'hF, 8'h00, 1'b0, 8'h20);
        tick(); idle();
        en_a = 1'b1; addr_a = 6'd2; en_b = 1'b1; addr_b = 6'd1;
        for (int i = 0; i < 4; i++) begin
            push(0, i, 8'h20, 1'b1); push(1, i, 8'h10, 1'b1);
        end
        tick(); idle();

        // Write-write collision
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd7; data_a = 8'hAA;
        en_b = 1'b1; we_b = 1'b1; addr_b = 6'd7; data_b = 8'hBB;
        wr(0, 4'hF, 8'h00, 1'b0, 8'hAA); wr(1, 4'hF, 8'h00, 1'b0, 8'hBB);
        for (int i = 0; i < 4; i++) col_q[i].push_back(cyc + 1);
        tick(); idle();
        en_a = 1'b1; addr_a = 6'd7;
        for (int i = 0; i < 4; i++) push(0, i, 8'hAA, 1'b1);
        tick(); idle();

        // Cross-port read of an address being written
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd9; data_a = 8'h11;
        wr(0, 4'hF, 8'h00, 1'b0, 8'h11);
        tick(); idle();
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd9; data_a = 8'hCC;
        en_b = 1'b1; addr_b = 6'd9;
        wr(0, 4'hF, 8'h11, 1'b1, 8'hCC);
        for (int i = 0; i < 4; i++) push(1, i, 8'h11, 1'b1);
        tick(); idle();
        en_b = 1'b1; addr_b = 6'd9;
        for (int i = 0; i < 4; i++) push(1, i, 8'hCC, 1'b1);
        tick(); idle();

        // Read-during-write modes on addr 3
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd3; data_a = 8'h01;
        wr(0, 4'hF, 8'h00, 1'b0, 8'h01);
        tick(); idle();
        en_a = 1'b1; addr_a = 6'd3;
        for (int i = 0; i < 4; i++) push(0, i, 8'h01, 1'b1);
        tick(); idle();
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd3; data_a = 8'h02;
        wr(0, 4'hF, 8'h01, 1'b1, 8'h02);
        tick(); idle();
        tick(); tick();
        chk("rdw_nochange_q", q_a[0], 8'h01);
        chk("rdw_readfirst_q", q_a[1], 8'h01);
        chk("rdw_writefirst_q", q_a[2], 8'h02);
        chk("rdw_nochange_outreg_q", q_a[3], 8'h01);

        // Back-to-back streaming reads
        ra[0] = 6'd1; ra[1] = 6'd2; ra[2] = 6'd3;
        rd[0] = 8'h10; rd[1] = 8'h20; rd[2] = 8'h02;
        for (int k = 0; k < 3; k++) begin
            en_a = 1'b1; addr_a = ra[k];
            for (int i = 0; i < 4; i++) push(0, i, rd[k], 1'b1);
            tick();
        end
        idle();
        repeat (5) tick();

        for (int j = 0; j < 8; j++) begin
            n_tests++;
            if (sb[j].size() != 0) begin
                n_fail++;
                $display("FAIL drain_rd_%0d: %0d expected reads never arrived", j, sb[j].size());
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (col_q[i].size() != 0) begin
                n_fail++;
                $display("FAIL drain_col_u%0d: %0d expected col_err pulses never arrived", i, col_q[i].size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_port_ram_cfg.md
Name: dual_port_ram_cfg

Overview:
Parametrised true dual-port synchronous RAM. Two independent read/write ports share one clock. It adds configurable width and depth, per-port enables and read-valid strobes, and a selectable read-during-write mode. It also has deterministic write-write collision handling, an optional output register and an optional post-reset memory-clear sweep. It is the general-purpose buffer RAM for packet and scratch storage in the design.

Parameters:
DATA_W, 8, data width in bits (1..64)
ADDR_W, 6, address width; DEPTH = 2**ADDR_W
RDW_MODE, 0, same-port read-during-write: 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST
OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1)
CLEAR_ON_RST, 1, 1 zeroes every location after reset via a sweep

Ports:
clk  in  1  single clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
en_a  in  1  port A access enable
we_a  in  1  port A write enable (qualified by en_a)
addr_a  in  ADDR_W  port A address
data_a  in  DATA_W  port A write data
q_a  out  DATA_W  port A read data
q_valid_a  out  1  q_a holds fresh read data this cycle
en_b, we_b, addr_b, data_b, q_b, q_valid_b  (same as port A, for port B)
busy  out  1  clear sweep in progress; accesses are ignored
col_err  out  1  one-cycle pulse: both ports wrote the same address in the same cycle

Behaviour:
- Reset (rst=1 at an edge): q_a, q_b = 0; q_valid_a, q_valid_b = 0; col_err = 0; OUT_REG pipeline stages = 0.
- Reset does not touch memory when CLEAR_ON_RST=0. In that case busy = 0.
- Clear FSM states: IDLE, CLEAR, READY.
  - rst forces CLEAR when CLEAR_ON_RST=1, otherwise READY. The clear counter resets to 0.
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. After writing DEPTH-1, go to READY. The sweep takes exactly DEPTH cycles after rst deasserts.
  - busy = 1 while in CLEAR and during the reset cycle itself.
  - rst during CLEAR restarts the sweep at address 0.
  - IDLE is the power-up encoding only.
- While busy: en_a and en_b are ignored; no writes, no reads, valids stay 0.
- Read (en=1, we=0): q <= mem[addr] at edge N. q_valid = 1 for the cycle after edge N (OUT_REG=0) or after edge N+1 (OUT_REG=1).
- When en=0, q holds its last value and q_valid = 0.
- Write (en=1, we=1): mem[addr] <= data at the edge. Same-port read behaviour depends on RDW_MODE:
  - NO_CHANGE: q holds its value; q_valid = 0.
  - READ_FIRST: q = old mem[addr]; q_valid = 1.
  - WRITE_FIRST: q = data; q_valid = 1.
- Cross-port read/write to the same address in the same cycle: the reader gets the old data.
- Both ports write the same address in the same cycle:
  - Port A's data is stored; port B's write is dropped.
  - col_err pulses for 1 cycle, aligned with the write edge (registered, visible the cycle after).
  - Each port's own q still follows RDW_MODE using its own data.
- Different addresses never interact. Addresses are full width, so there is no out-of-range case.
- OUT_REG=1: q and q_valid both pass through one extra register stage. Back-to-back reads stream at one per cycle.

Decomposition:
- Package dpram_pkg holds:
  - RDW mode constants RDW_NO_CHANGE=0, RDW_READ_FIRST=1, RDW_WRITE_FIRST=2.
  - Clear FSM state encoding IDLE, CLEAR, READY (2 bits).
- Sub-module dpram_port_out, instantiated once per port. It implements RDW_MODE selection, the valid strobe and the optional OUT_REG stage.
- Memory array, collision detection and clear FSM live in the top level.

Test Plan:
- Basic access, DATA_W=8, ADDR_W=6, CLEAR_ON_RST=0: write A@1=0x10 and B@2=0x20, then read A@2 and B@1 -> q_a=0x20, q_b=0x10, both valids high one cycle after the read edge.
- Clear sweep, CLEAR_ON_RST=1: release rst; busy is high for exactly 64 cycles. A write of 0x55 to addr 5 issued while busy is ignored. After busy falls, reading addr 5 and addr 63 returns 0x00.
- Reset mid-clear: assert rst at sweep cycle 20 -> busy stays high and the sweep restarts, ending 64 cycles after the new rst deassertion.
- Collision: both ports write addr 7 in the same cycle, A=0xAA, B=0xBB -> col_err pulses once; a later read of addr 7 returns 0xAA. Cross-port case: A writes 0xCC to addr 9 (holding 0x11) while B reads addr 9 -> q_b=0x11.
- RDW modes on addr 3 holding 0x01, port A writes 0x02:
  - NO_CHANGE -> q_a unchanged, q_valid_a=0.
  - READ_FIRST -> q_a=0x01.
  - WRITE_FIRST -> q_a=0x02.
- OUT_REG=1: reads of addr 1, 2, 3 on consecutive cycles -> data appears two edges after each read, on three consecutive cycles, each with q_valid_a=1.
